key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//   Per-key synchronizer and debouncer for the raw active-low push-buttons.
//   Sits between the board key pins and key_scan: key_out drives key_scan's
//   key input directly, so key_scan only ever sees settled key levels.
//   Also emits one-cycle press/release strobes for logic that wants edges.
// PARAMETERS
//   KEY_W           4          number of independent keys
//   DEBOUNCE_CYCLES 1_000_000  consecutive stable cycles required (20 ms @ 50 MHz); legal range >= 2
//   CNT_W           20         counter width; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//   sys_clk      in   1      50 MHz system clock; all logic on its rising edge
//   sys_rst      in   1      synchronous reset, active-high
//   key_in       in   KEY_W  raw key pins, asynchronous, active-low (0 = pressed)
//   key_out      out  KEY_W  debounced key level, active-low; feeds key_scan
//   key_press    out  KEY_W  1-cycle pulse when a key's key_out goes 1->0
//   key_release  out  KEY_W  1-cycle pulse when a key's key_out goes 0->1
//   key_any      out  1      1 while any bit of key_out is 0
// BEHAVIOUR
//   Reset (sys_rst=1 at a sys_clk edge):
//   - key_out = all 1s; key_press = key_release = 0; key_any = 0.
//   - Both synchronizer stages = all 1s; all counters = 0; all keys in STABLE.
//   - This guarantees no spurious press strobe after reset.
//   - Reset mid-count discards the count and pending transitions.
//   Synchronizer: 2-flop chain per key; ks = second stage.
//   Per-key FSM (every key independent, no priority between keys):
//   - STABLE: cnt = 0. If ks != key_out, go to COUNT with cnt = 1.
//   - COUNT, ks == key_out: glitch rejected; back to STABLE, cnt = 0,
//     no strobe.
//   - COUNT, ks != key_out, cnt < DEBOUNCE_CYCLES-1: cnt++.
//   - COUNT, ks != key_out, cnt == DEBOUNCE_CYCLES-1: toggle key_out,
//     pulse press (new 0) or release (new 1) for exactly one cycle,
//     cnt = 0, go to STABLE.
//   Latency:
//   - A level change on key_in that stays stable sets key_out (and the
//     strobe) on the (DEBOUNCE_CYCLES+2)th rising edge after the first
//     edge that samples it.
//   - key_press and key_release are registered and coincide with the
//     key_out change.
//   - key_any is combinational from key_out: ~&key_out.
//   Boundary conditions:
//   - A bounce shorter than DEBOUNCE_CYCLES cycles causes no output change.
//   - Bounce restarts the count from 0 every time.
//   - The counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is
//     possible.
//   - Simultaneous presses on several keys produce simultaneous independent
//     strobes. key_scan itself ignores multi-key patterns.
//   - key_press and key_release are never both 1 on the same bit in the
//     same cycle.
//   - A key held indefinitely produces one key_press only; there is no
//     auto-repeat.
// TESTING  (bench overrides DEBOUNCE_CYCLES=16)
//   1. Reset with key_in=4'b1111, release reset
//      -> key_out=4'b1111, no strobes for 100 cycles.
//   2. key_in[0]=0 held
//      -> key_out=4'b1110 and key_press=4'b0001 for 1 cycle, exactly
//         18 edges after first sample; key_any=1.
//   3. key_in[1] toggles 0/1 every 5 cycles for 200 cycles, then held 1
//      -> key_out[1] stays 1, key_press[1] never asserts.
//   4. Release key 0 after it is debounced
//      -> key_release=4'b0001 for 1 cycle, 18 edges after release;
//         key_any=0.
//   5. key_in[2] and key_in[3] drop on the same edge
//      -> key_press=4'b1100 in one cycle; key_out=4'b0011.
//   6. Assert sys_rst at cnt=10 of a pending press on key 0, hold key_in
//      low through reset
//      -> key_out=4'b1111 during reset; press strobe appears 18 edges
//         after reset deasserts.

Source files
------------

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus per-key debounce FSM for active-low push-buttons.
// key_out only changes after DEBOUNCE_CYCLES consecutive cycles at the new level.
//
//   state     | meaning
//   ST_STABLE | key_out matches synchronized input, counter idle at 0
//   ST_COUNT  | synchronized input differs from key_out, counting stable cycles
module key_debounce #(
    parameter int KEY_W           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_out,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic             key_any
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0] sync1;
    logic [KEY_W-1:0] ks;
    state_t           state [KEY_W];
    logic [CNT_W-1:0] cnt   [KEY_W];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1       <= '1;
            ks          <= '1;
            key_out     <= '1;
            key_press   <= '0;
            key_release <= '0;
            for (int i = 0; i < KEY_W; i++) begin
                state[i] <= ST_STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            sync1 <= key_in;
            ks    <= sync1;
            for (int i = 0; i < KEY_W; i++) begin
                key_press[i]   <= 1'b0;
                key_release[i] <= 1'b0;
                case (state[i])
                    ST_STABLE: begin
                        cnt[i] <= '0;
                        if (ks[i] != key_out[i]) begin
                            state[i] <= ST_COUNT;
                            cnt[i]   <= CNT_W'(1);
                        end
                    end
                    ST_COUNT: begin
                        // Any return to the old level is a bounce: restart from zero.
                        if (ks[i] == key_out[i]) begin
                            state[i] <= ST_STABLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            state[i]       <= ST_STABLE;
                            cnt[i]         <= '0;
                            key_out[i]     <= ks[i];
                            key_press[i]   <= ~ks[i];
                            key_release[i] <= ks[i];
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state[i] <= ST_STABLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign key_any = ~&key_out;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus queues expected strobe events,
// a monitor pops and compares them whenever the DUT emits a strobe.
module tb_key_debounce;

    localparam int KEY_W = 4;
    localparam int DEB   = 16;
    localparam int LAT   = DEB + 2;

    logic             sys_clk = 1'b0;
    logic             sys_rst;
    logic [KEY_W-1:0] key_in;
    logic [KEY_W-1:0] key_out;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;
    logic             key_any;

    key_debounce #(
        .KEY_W          (KEY_W),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (5)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .key_out    (key_out),
        .key_press  (key_press),
        .key_release(key_release),
        .key_any    (key_any)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] out;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] o);
        exp_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.out   = o;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe cycle must match the next queued expectation.
    always @(negedge sys_clk) begin
        if ((key_press | key_release) != 4'b0000) begin
            exp_t e;
            chk("press_release_exclusive", 32'(key_press & key_release), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {key_press, key_release}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                chk("key_press", 32'(key_press), 32'(e.press));
                chk("key_release", 32'(key_release), 32'(e.rel));
                chk("key_out_at_strobe", 32'(key_out), 32'(e.out));
                chk("key_any_at_strobe", 32'(key_any), 32'(e.out != 4'b1111));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        sys_rst = 1'b1;
        key_in  = 4'b1111;
        wait_cyc(3);
        chk("reset_key_out", 32'(key_out), 32'hF);
        chk("reset_key_any", 32'(key_any), 32'd0);
        chk("reset_strobes", {key_press, key_release}, 32'd0);
        sys_rst = 1'b0;
        wait_cyc(100);
        chk("idle_key_out", 32'(key_out), 32'hF);

        // Single press on key 0
        key_in = 4'b1110;
        n = cyc;
        push(n + LAT, 4'b0001, 4'b0000, 4'b1110);
        wait_cyc(LAT - 1);
        chk("press_not_early", 32'(key_out), 32'hF);
        wait_cyc(1);
        chk("press_key_out", 32'(key_out), 32'hE);
        chk("press_key_any", 32'(key_any), 32'd1);
        wait_cyc(1);
        chk("press_one_cycle", 32'(key_press), 32'd0);
        wait_cyc(10);

        // Bouncing key 1: period 10 never reaches 16 stable cycles
        for (int t = 0; t < 40; t++) begin
            key_in[1] = t[0];
            wait_cyc(5);
        end
        key_in[1] = 1'b1;
        wait_cyc(30);
        chk("bounce_key_out", 32'(key_out), 32'hE);

        // Release key 0
        key_in = 4'b1111;
        n = cyc;
        push(n + LAT, 4'b0000, 4'b0001, 4'b1111);
        wait_cyc(LAT);
        chk("release_key_any", 32'(key_any), 32'd0);
        wait_cyc(10);

        // Simultaneous press and release on keys 2 and 3
        key_in = 4'b0011;
        n = cyc;
        push(n + LAT, 4'b1100, 4'b0000, 4'b0011);
        wait_cyc(LAT);
        chk("multi_key_out", 32'(key_out), 32'h3);
        wait_cyc(5);
        key_in = 4'b1111;
        n = cyc;
        push(n + LAT, 4'b0000, 4'b1100, 4'b1111);
        wait_cyc(LAT + 5);

        // Reset during a pending press on key 0 (cnt reaches 10, then reset)
        key_in = 4'b1110;
        wait_cyc(12);
        sys_rst = 1'b1;
        wait_cyc(1);
        chk("midreset_key_out", 32'(key_out), 32'hF);
        wait_cyc(2);
        chk("midreset_hold_key_out", 32'(key_out), 32'hF);
        sys_rst = 1'b0;
        n = cyc;
        push(n + LAT, 4'b0001, 4'b0000, 4'b1110);
        wait_cyc(LAT - 1);
        chk("postreset_not_early", 32'(key_out), 32'hF);
        wait_cyc(1);
        chk("postreset_key_out", 32'(key_out), 32'hE);
        wait_cyc(5);
        key_in = 4'b1111;
        n = cyc;
        push(n + LAT, 4'b0000, 4'b0001, 4'b1111);
        wait_cyc(LAT + 10);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
